// File: rtl/attack_fsm_pkg.sv
// Shared types and constants for the attacker-side FSM and its hitbox logic.
// The package is named attack_pkg so that hit FSMs and projectiles can import it too.
package attack_pkg;

    localparam int COORD_W = 10;
    localparam int BOUND_W = COORD_W + 1;
    localparam int DMG_W   = 6;
    localparam int CNT_W   = 8;

    localparam logic [DMG_W-1:0] JAB_DAMAGE_DEF   = 6'd5;
    localparam logic [DMG_W-1:0] SMASH_DAMAGE_DEF = 6'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_ACTIVE,
        ST_RECOVERY
    } atk_state_t;

    typedef enum logic {
        TYPE_JAB,
        TYPE_SMASH
    } atk_type_t;

    localparam logic [3:0] ANIM_IDLE           = 4'd0;
    localparam logic [3:0] ANIM_JAB_STARTUP    = 4'd1;
    localparam logic [3:0] ANIM_JAB_ACTIVE     = 4'd2;
    localparam logic [3:0] ANIM_JAB_RECOVERY   = 4'd3;
    localparam logic [3:0] ANIM_SMASH_STARTUP  = 4'd5;
    localparam logic [3:0] ANIM_SMASH_ACTIVE   = 4'd6;
    localparam logic [3:0] ANIM_SMASH_RECOVERY = 4'd7;

    function automatic logic [3:0] anim_decode(input atk_state_t st, input atk_type_t ty);
        logic [3:0] id;
        id = ANIM_IDLE;
        case (st)
            ST_STARTUP:  id = (ty == TYPE_SMASH) ? ANIM_SMASH_STARTUP  : ANIM_JAB_STARTUP;
            ST_ACTIVE:   id = (ty == TYPE_SMASH) ? ANIM_SMASH_ACTIVE   : ANIM_JAB_ACTIVE;
            ST_RECOVERY: id = (ty == TYPE_SMASH) ? ANIM_SMASH_RECOVERY : ANIM_JAB_RECOVERY;
            default:     id = ANIM_IDLE;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/attack_fsm_if.sv
// Signal bundle between the input/position logic, the attack FSM and the opponent's hit FSM.
interface attack_fsm_if;

    logic                                  frame_tick;
    logic                                  attack_btn;
    logic                                  special_btn;
    logic                                  facing_left;
    logic                                  hit_stun_active;
    logic [attack_pkg::COORD_W-1:0]        pos_x;
    logic [attack_pkg::COORD_W-1:0]        pos_y;
    logic [attack_pkg::COORD_W-1:0]        opp_x;
    logic [attack_pkg::COORD_W-1:0]        opp_y;
    logic                                  got_hit_out;
    logic [attack_pkg::DMG_W-1:0]          hit_damage_out;
    logic                                  attack_active;
    logic                                  busy;
    logic [3:0]                            attack_anim_id;

    modport slave (
        input  frame_tick, attack_btn, special_btn, facing_left, hit_stun_active,
        input  pos_x, pos_y, opp_x, opp_y,
        output got_hit_out, hit_damage_out, attack_active, busy, attack_anim_id
    );

    modport master (
        output frame_tick, attack_btn, special_btn, facing_left, hit_stun_active,
        output pos_x, pos_y, opp_x, opp_y,
        input  got_hit_out, hit_damage_out, attack_active, busy, attack_anim_id
    );

endinterface

// File: rtl/hitbox_overlap.sv
// Combinational directional-hitbox vs hurtbox overlap test.
// Bounds are widened to 11 bits so nothing wraps near the right/bottom screen edge.
module hitbox_overlap
    import attack_pkg::*;
#(
    parameter int OFS    = 16,
    parameter int W      = 24,
    parameter int H      = 16,
    parameter int HURT_W = 32,
    parameter int HURT_H = 48
) (
    input  logic               facing_left,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [COORD_W-1:0] opp_x,
    input  logic [COORD_W-1:0] opp_y,
    output logic               overlap
);

    localparam logic [BOUND_W-1:0] OFS_B    = BOUND_W'(OFS);
    localparam logic [BOUND_W-1:0] W_B      = BOUND_W'(W);
    localparam logic [BOUND_W-1:0] H_B      = BOUND_W'(H);
    localparam logic [BOUND_W-1:0] HURT_W_B = BOUND_W'(HURT_W);
    localparam logic [BOUND_W-1:0] HURT_H_B = BOUND_W'(HURT_H);

    logic [BOUND_W-1:0] px, py, ox, oy;
    logic [BOUND_W-1:0] hb_lo_x, hb_hi_x, hb_lo_y, hb_hi_y;
    logic [BOUND_W-1:0] hu_lo_x, hu_hi_x, hu_lo_y, hu_hi_y;

    assign px = {1'b0, pos_x};
    assign py = {1'b0, pos_y};
    assign ox = {1'b0, opp_x};
    assign oy = {1'b0, opp_y};

    // Facing left the box sits behind pos_x; both edges clamp at 0 rather than wrap.
    always_comb begin
        hb_lo_x = px + OFS_B;
        hb_hi_x = px + OFS_B + W_B;
        if (facing_left) begin
            hb_lo_x = (px >= OFS_B + W_B) ? (px - OFS_B - W_B) : '0;
            hb_hi_x = (px >= OFS_B)       ? (px - OFS_B)       : '0;
        end
    end

    assign hb_lo_y = py;
    assign hb_hi_y = py + H_B;
    assign hu_lo_x = ox;
    assign hu_hi_x = ox + HURT_W_B;
    assign hu_lo_y = oy;
    assign hu_hi_y = oy + HURT_H_B;

    assign overlap = (hb_lo_x < hu_hi_x) && (hu_lo_x < hb_hi_x) &&
                     (hb_lo_y < hu_hi_y) && (hu_lo_y < hb_hi_y);

endmodule

// File: rtl/attack_fsm.sv
// Attacker FSM: button edges -> startup/active/recovery phases, one hit pulse per attack.
// Optional ATTACK_BUFFER_EN: a press during recovery chains straight into the next startup.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no attack; waits for a jab/smash edge with hitstun clear
// ST_STARTUP  | wind-up, counter holds remaining startup frames
// ST_ACTIVE   | hitbox live, one overlap evaluation per frame_tick
// ST_RECOVERY | cool-down, counter holds remaining recovery frames
module attack_fsm
    import attack_pkg::*;
#(
    parameter int               STARTUP_FRAMES       = 4,
    parameter int               SMASH_STARTUP_FRAMES = 8,
    parameter int               ACTIVE_FRAMES        = 3,
    parameter int               RECOVERY_FRAMES      = 10,
    parameter logic [DMG_W-1:0] JAB_DAMAGE           = JAB_DAMAGE_DEF,
    parameter logic [DMG_W-1:0] SMASH_DAMAGE         = SMASH_DAMAGE_DEF,
    parameter int               HITBOX_OFS_X         = 16,
    parameter int               HITBOX_W             = 24,
    parameter int               HITBOX_H             = 16,
    parameter int               HURT_W               = 32,
    parameter int               HURT_H               = 48
) (
    input  logic        clk,
    input  logic        reset,
    attack_fsm_if.slave bus
);

    atk_state_t       state_q, state_d;
    atk_type_t        type_q, type_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             connected_q, connected_d;
    logic             got_hit_q, got_hit_d;
    logic [DMG_W-1:0] dmg_q, dmg_d;
    logic             atk_prev_q, spc_prev_q;

`ifdef ATTACK_BUFFER_EN
    logic             buf_valid_q, buf_valid_d;
    atk_type_t        buf_type_q, buf_type_d;
`endif

    logic             jab_edge, smash_edge, start_req, overlap;
    atk_type_t        start_type;

    hitbox_overlap #(
        .OFS    (HITBOX_OFS_X),
        .W      (HITBOX_W),
        .H      (HITBOX_H),
        .HURT_W (HURT_W),
        .HURT_H (HURT_H)
    ) u_hitbox (
        .facing_left (bus.facing_left),
        .pos_x       (bus.pos_x),
        .pos_y       (bus.pos_y),
        .opp_x       (bus.opp_x),
        .opp_y       (bus.opp_y),
        .overlap     (overlap)
    );

    assign jab_edge   = bus.attack_btn  & ~atk_prev_q;
    assign smash_edge = bus.special_btn & ~spc_prev_q;
    assign start_req  = jab_edge | smash_edge;
    assign start_type = smash_edge ? TYPE_SMASH : TYPE_JAB;

    function automatic logic [CNT_W-1:0] startup_len(input atk_type_t t);
        return (t == TYPE_SMASH) ? CNT_W'(SMASH_STARTUP_FRAMES) : CNT_W'(STARTUP_FRAMES);
    endfunction

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        connected_d = connected_q;
        got_hit_d   = 1'b0;
        dmg_d       = dmg_q;
`ifdef ATTACK_BUFFER_EN
        buf_valid_d = buf_valid_q;
        buf_type_d  = buf_type_q;
`endif
        if (state_q == ST_IDLE) begin
            if (start_req && !bus.hit_stun_active) begin
                state_d     = ST_STARTUP;
                type_d      = start_type;
                cnt_d       = startup_len(start_type);
                connected_d = 1'b0;
            end
        end else if (bus.hit_stun_active) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
`ifdef ATTACK_BUFFER_EN
            buf_valid_d = 1'b0;
`endif
        end else begin
`ifdef ATTACK_BUFFER_EN
            if (state_q == ST_RECOVERY && start_req) begin
                buf_valid_d = 1'b1;
                buf_type_d  = start_type;
            end
`endif
            if (bus.frame_tick) begin
                // Evaluate against the current phase before the counter moves on.
                if (state_q == ST_ACTIVE && overlap && !connected_q) begin
                    got_hit_d   = 1'b1;
                    dmg_d       = (type_q == TYPE_SMASH) ? SMASH_DAMAGE : JAB_DAMAGE;
                    connected_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    case (state_q)
                        ST_STARTUP: begin
                            state_d = ST_ACTIVE;
                            cnt_d   = CNT_W'(ACTIVE_FRAMES);
                        end
                        ST_ACTIVE: begin
                            state_d = ST_RECOVERY;
                            cnt_d   = CNT_W'(RECOVERY_FRAMES);
                        end
                        default: begin
`ifdef ATTACK_BUFFER_EN
                            if (buf_valid_d) begin
                                state_d     = ST_STARTUP;
                                type_d      = buf_type_d;
                                cnt_d       = startup_len(buf_type_d);
                                connected_d = 1'b0;
                                buf_valid_d = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end
`else
                            state_d = ST_IDLE;
                            cnt_d   = '0;
`endif
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            type_q      <= TYPE_JAB;
            cnt_q       <= '0;
            connected_q <= 1'b0;
            got_hit_q   <= 1'b0;
            dmg_q       <= '0;
`ifdef ATTACK_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_type_q  <= TYPE_JAB;
`endif
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            connected_q <= connected_d;
            got_hit_q   <= got_hit_d;
            dmg_q       <= dmg_d;
`ifdef ATTACK_BUFFER_EN
            buf_valid_q <= buf_valid_d;
            buf_type_q  <= buf_type_d;
`endif
        end
    end

    // Edge history keeps sampling through reset so a button held across release is not a press.
    always_ff @(posedge clk) begin
        atk_prev_q <= bus.attack_btn;
        spc_prev_q <= bus.special_btn;
    end

    assign bus.got_hit_out    = got_hit_q;
    assign bus.hit_damage_out = dmg_q;
    assign bus.attack_active  = (state_q == ST_ACTIVE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.attack_anim_id = anim_decode(state_q, type_q);

endmodule
